// File: rtl/oflow_mem_buffer_ctrl_pkg.sv
// History-frame MEM buffer sequencer: shared types and helpers.
// FSM encoding, table depth and per-N region sizing.
package oflow_mem_buffer_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam int MAX_HIST = 5;

    // Objects that fit in one frame region when the buffer is split N ways.
    function automatic logic [7:0] region_size(input logic [2:0] n);
        logic [7:0] r;
        case (n)
            3'd1:    r = 8'd128;
            3'd2:    r = 8'd64;
            3'd3:    r = 8'd42;
            3'd4:    r = 8'd32;
            3'd5:    r = 8'd25;
            default: r = 8'd0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/oflow_mem_buffer_rd_pipe.sv
// Read-return tag pipe: carries valid plus tag for the buffer read latency.
// empty is low while any issued read has not yet returned.
module oflow_mem_buffer_rd_pipe #(
    parameter int LAT   = 1,
    parameter int TAG_W = 11
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    output logic [TAG_W-1:0] out_tag,
    output logic             empty
);

    logic [LAT-1:0] vld_q;
    logic [TAG_W-1:0] tag_q [LAT];

    // Shift valid and tag one stage per cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q <= '0;
            tag_q <= '{default: '0};
        end else begin
            vld_q[0] <= in_valid;
            tag_q[0] <= in_tag;
            for (int i = 1; i < LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    assign out_valid = vld_q[LAT-1];
    assign out_tag   = tag_q[LAT-1];
    assign empty     = ~|vld_q;

endmodule

// File: rtl/oflow_mem_buffer_ctrl.sv
// Per-frame sequencer for the two-port history-frame MEM buffer.
// Writes the new frame pairwise, streams history newest first, bumps frame.
module oflow_mem_buffer_ctrl
    import oflow_mem_buffer_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH                  = 32,
    parameter int OFFSET_WIDTH                = 7,
    parameter int TOTAL_FRAME_NUM_WIDTH       = 8,
    parameter int NUM_OF_HISTORY_FRAMES_WIDTH = 3,
    parameter int MEM_RD_LAT                  = 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic [NUM_OF_HISTORY_FRAMES_WIDTH-1:0] num_of_history_frames,
    input  logic [OFFSET_WIDTH-1:0]          obj_count,
    input  logic                             wr_valid,
    output logic                             wr_ready,
    input  logic [DATA_WIDTH-1:0]            wr_data_0,
    input  logic [DATA_WIDTH-1:0]            wr_data_1,
    output logic                             rd_valid,
    output logic [DATA_WIDTH-1:0]            rd_data_0,
    output logic [DATA_WIDTH-1:0]            rd_data_1,
    output logic [NUM_OF_HISTORY_FRAMES_WIDTH-1:0] rd_hist_depth,
    output logic [OFFSET_WIDTH-1:0]          rd_offset,
    output logic                             rd_pair,
    output logic [TOTAL_FRAME_NUM_WIDTH-1:0] frame_num,
    output logic                             busy,
    output logic                             done,
    output logic                             cfg_err,
    output logic [TOTAL_FRAME_NUM_WIDTH-1:0] mem_frame_num,
    output logic [OFFSET_WIDTH-1:0]          mem_offset_0,
    output logic [OFFSET_WIDTH-1:0]          mem_offset_1,
    output logic                             mem_csb_0,
    output logic                             mem_csb_1,
    output logic                             mem_we,
    output logic                             mem_oeb,
    output logic [DATA_WIDTH-1:0]            mem_data_in_0,
    output logic [DATA_WIDTH-1:0]            mem_data_in_1,
    input  logic [DATA_WIDTH-1:0]            mem_data_out_0,
    input  logic [DATA_WIDTH-1:0]            mem_data_out_1
);

    localparam int OW = OFFSET_WIDTH;
    localparam int FW = TOTAL_FRAME_NUM_WIDTH;
    localparam int HW = NUM_OF_HISTORY_FRAMES_WIDTH;
    localparam int TW = HW + OW + 1;
    localparam logic [OW:0] P_ONE = (OW+1)'(1);
    localparam logic [OW:0] P_TWO = (OW+1)'(2);

    state_t          state_q, state_d;
    logic [FW-1:0]   frame_num_q;
    logic [HW-1:0]   fs_q, n_q, rd_k_q;
    logic [OW-1:0]   cnt_q;
    logic [OW:0]     wr_ptr_q, rd_ptr_q;
    logic [OW-1:0]   count_q [MAX_HIST];
    logic            cfg_err_q;

    logic [7:0]      region;
    logic            n_bad, n_mis, clamp, start_err, accept;
    logic [OW-1:0]   cnt_in;
    logic [2:0]      acc_idx, wr_idx, rd_idx;
    logic            wr_fire, wr_last, wr_odd;
    logic [OW:0]     wr_ptr_p1, wr_ptr_p2, rd_ptr_p1, rd_ptr_p2;
    logic [HW-1:0]   n_m1, k_max;
    logic            k_done;
    logic [FW-1:0]   rd_frame;
    logic [OW-1:0]   rd_cnt;
    logic            rd_issue, rd_pair_iss, k_adv;
    logic            pipe_valid, pipe_empty;
    logic [TW-1:0]   pipe_tag;

    assign region    = region_size(num_of_history_frames);
    assign n_bad     = (num_of_history_frames == '0) ||
                       (num_of_history_frames > HW'(MAX_HIST));
    assign n_mis     = (frame_num_q != '0) && (num_of_history_frames != n_q);
    assign clamp     = 32'(obj_count) > 32'(region);
    assign start_err = (state_q == S_IDLE) && start && (n_bad || n_mis || clamp);
    assign accept    = (state_q == S_IDLE) && start && !n_bad && !n_mis;
    assign cnt_in    = clamp ? OW'(region) : obj_count;
    assign acc_idx   = 3'(frame_num_q % FW'(num_of_history_frames));
    assign wr_idx    = 3'(frame_num_q % FW'(n_q));

    assign wr_ptr_p1 = wr_ptr_q + P_ONE;
    assign wr_ptr_p2 = wr_ptr_q + P_TWO;
    assign wr_fire   = (state_q == S_WRITE) && wr_valid;
    assign wr_last   = wr_ptr_p2 >= {1'b0, cnt_q};
    assign wr_odd    = wr_ptr_p1 == {1'b0, cnt_q};

    assign n_m1      = n_q - HW'(1);
    assign k_max     = (fs_q < n_m1) ? fs_q : n_m1;
    assign k_done    = rd_k_q > k_max;
    assign rd_frame  = frame_num_q - FW'(rd_k_q);
    assign rd_idx    = 3'(rd_frame % FW'(n_q));
    assign rd_cnt    = count_q[rd_idx];
    assign rd_ptr_p1 = rd_ptr_q + P_ONE;
    assign rd_ptr_p2 = rd_ptr_q + P_TWO;
    assign rd_issue  = (state_q == S_READ) && !k_done &&
                       (rd_ptr_q < {1'b0, rd_cnt});
    assign rd_pair_iss = rd_ptr_p1 < {1'b0, rd_cnt};
    assign k_adv     = (state_q == S_READ) && !k_done &&
                       (rd_ptr_p2 >= {1'b0, rd_cnt});

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next state and buffer controls; controls are idle unless a beat or read fires.
    always_comb begin
        state_d       = state_q;
        wr_ready      = 1'b0;
        done          = 1'b0;
        mem_frame_num = '0;
        mem_offset_0  = '0;
        mem_offset_1  = '0;
        mem_csb_0     = 1'b1;
        mem_csb_1     = 1'b1;
        mem_we        = 1'b0;
        mem_oeb       = 1'b1;
        mem_data_in_0 = '0;
        mem_data_in_1 = '0;
        unique case (state_q)
            S_IDLE: begin
                if (accept) state_d = (cnt_in == '0) ? S_READ : S_WRITE;
            end
            S_WRITE: begin
                wr_ready = 1'b1;
                if (wr_fire) begin
                    mem_we        = 1'b1;
                    mem_frame_num = frame_num_q;
                    mem_offset_0  = wr_ptr_q[OW-1:0];
                    mem_offset_1  = wr_ptr_p1[OW-1:0];
                    mem_csb_0     = 1'b0;
                    mem_csb_1     = wr_odd;
                    mem_data_in_0 = wr_data_0;
                    mem_data_in_1 = wr_data_1;
                    if (wr_last) state_d = S_READ;
                end
            end
            S_READ: begin
                if (k_done) state_d = S_DRAIN;
                if (rd_issue) begin
                    mem_oeb       = 1'b0;
                    mem_frame_num = rd_frame;
                    mem_offset_0  = rd_ptr_q[OW-1:0];
                    mem_offset_1  = rd_ptr_p1[OW-1:0];
                    mem_csb_0     = 1'b0;
                    mem_csb_1     = !rd_pair_iss;
                end
            end
            S_DRAIN: begin
                if (pipe_empty) state_d = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Frame bookkeeping: latch config, walk pointers, commit count, advance frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_num_q <= '0;
            fs_q        <= '0;
            n_q         <= '0;
            cnt_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            rd_k_q      <= '0;
            cfg_err_q   <= 1'b0;
            count_q     <= '{default: '0};
        end else begin
            cfg_err_q <= start_err;
            if (accept) begin
                n_q      <= num_of_history_frames;
                cnt_q    <= cnt_in;
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                rd_k_q   <= HW'(1);
                if (cnt_in == '0) count_q[acc_idx] <= '0;
            end
            if (wr_fire) begin
                wr_ptr_q <= wr_ptr_p2;
                if (wr_last) count_q[wr_idx] <= cnt_q;
            end
            if (rd_issue) rd_ptr_q <= rd_ptr_p2;
            if (k_adv) begin
                rd_k_q   <= rd_k_q + HW'(1);
                rd_ptr_q <= '0;
            end
            if (state_q == S_DONE) begin
                frame_num_q <= frame_num_q + FW'(1);
                if (frame_num_q == '1)   fs_q <= '0;
                else if (fs_q < n_m1)    fs_q <= fs_q + HW'(1);
                else                     fs_q <= n_m1;
            end
        end
    end

    oflow_mem_buffer_rd_pipe #(
        .LAT   (MEM_RD_LAT),
        .TAG_W (TW)
    ) u_rd_pipe (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (rd_issue),
        .in_tag    ({rd_k_q, rd_ptr_q[OW-1:0], rd_pair_iss}),
        .out_valid (pipe_valid),
        .out_tag   (pipe_tag),
        .empty     (pipe_empty)
    );

    assign rd_valid = pipe_valid;
    assign {rd_hist_depth, rd_offset, rd_pair} = pipe_tag;
    assign rd_data_0 = pipe_valid ? mem_data_out_0 : '0;
    assign rd_data_1 = (pipe_valid && pipe_tag[0]) ? mem_data_out_1 : '0;
    assign frame_num = frame_num_q;
    assign busy      = (state_q != S_IDLE);
    assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_oflow_mem_buffer_ctrl.sv
// Randomized bench for oflow_mem_buffer_ctrl with an emulated buffer.
// Expectations come from a frame-level model of counts and history depth.
module tb_oflow_mem_buffer_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  num_of_history_frames;
    logic [6:0]  obj_count;
    logic        wr_valid, wr_ready;
    logic [31:0] wr_data_0, wr_data_1;
    logic        rd_valid;
    logic [31:0] rd_data_0, rd_data_1;
    logic [2:0]  rd_hist_depth;
    logic [6:0]  rd_offset;
    logic        rd_pair;
    logic [7:0]  frame_num;
    logic        busy, done, cfg_err;
    logic [7:0]  mem_frame_num;
    logic [6:0]  mem_offset_0, mem_offset_1;
    logic        mem_csb_0, mem_csb_1, mem_we, mem_oeb;
    logic [31:0] mem_data_in_0, mem_data_in_1;
    logic [31:0] mem_data_out_0, mem_data_out_1;

    oflow_mem_buffer_ctrl dut (
        .clk                   (clk),
        .reset                 (reset),
        .start                 (start),
        .num_of_history_frames (num_of_history_frames),
        .obj_count             (obj_count),
        .wr_valid              (wr_valid),
        .wr_ready              (wr_ready),
        .wr_data_0             (wr_data_0),
        .wr_data_1             (wr_data_1),
        .rd_valid              (rd_valid),
        .rd_data_0             (rd_data_0),
        .rd_data_1             (rd_data_1),
        .rd_hist_depth         (rd_hist_depth),
        .rd_offset             (rd_offset),
        .rd_pair               (rd_pair),
        .frame_num             (frame_num),
        .busy                  (busy),
        .done                  (done),
        .cfg_err               (cfg_err),
        .mem_frame_num         (mem_frame_num),
        .mem_offset_0          (mem_offset_0),
        .mem_offset_1          (mem_offset_1),
        .mem_csb_0             (mem_csb_0),
        .mem_csb_1             (mem_csb_1),
        .mem_we                (mem_we),
        .mem_oeb               (mem_oeb),
        .mem_data_in_0         (mem_data_in_0),
        .mem_data_in_1         (mem_data_in_1),
        .mem_data_out_0        (mem_data_out_0),
        .mem_data_out_1        (mem_data_out_1)
    );

    always #5 clk = ~clk;

    typedef struct {
        int k;
        int f;
        int off;
        bit pair;
        int cyc;
    } rd_t;

    logic [31:0] mem   [256][128];
    logic [31:0] ref_d [256][128];
    int rtab [6] = '{0, 128, 64, 42, 32, 25};
    int m_fn, m_fs, m_n;
    int m_cnt [5];
    int vectors = 0;
    int errors  = 0;
    rd_t rq[$];
    rd_t pq[$];

    // Two-port buffer model: writes land at the edge, reads return one cycle later.
    always @(posedge clk) begin
        if (mem_we && !mem_csb_0) mem[mem_frame_num][mem_offset_0] <= mem_data_in_0;
        if (mem_we && !mem_csb_1) mem[mem_frame_num][mem_offset_1] <= mem_data_in_1;
        if (!mem_oeb) begin
            mem_data_out_0 <= !mem_csb_0 ? mem[mem_frame_num][mem_offset_0] : 32'h0;
            mem_data_out_1 <= !mem_csb_1 ? mem[mem_frame_num][mem_offset_1] : 32'h0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (frame %0d)", tag, got, exp, m_fn);
        end
    endtask

    task automatic model_reset();
        m_fn = 0;
        m_fs = 0;
        m_n  = 0;
        foreach (m_cnt[i]) m_cnt[i] = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        start = 1'b0;
        wr_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic run_frame(input int n, input int oc, input bit inject);
        bit acc, clampf, bad, mis;
        int r, cnt, beats, wb, kmax, c, f;
        rd_t e;
        bad = (n == 0) || (n > 5);
        mis = (m_fn != 0) && (n != m_n);
        acc = !bad && !mis;
        r = acc ? rtab[n] : 0;
        clampf = acc && (oc > r);
        @(negedge clk);
        start = 1'b1;
        num_of_history_frames = 3'(n);
        obj_count = 7'(oc);
        wr_valid = 1'b0;
        @(posedge clk);
        #1;
        check("cfg_err_on_start", cfg_err, 32'(!acc || clampf));
        check("busy_on_start", busy, 32'(acc));
        if (!acc) begin
            @(negedge clk);
            start = 1'b0;
            @(posedge clk);
            #1;
            check("cfg_err_pulse_end", cfg_err, 0);
            check("rejected_busy", busy, 0);
            check("rejected_frame_num", frame_num, m_fn);
            return;
        end
        cnt = clampf ? r : oc;
        beats = (cnt + 1) / 2;
        kmax = (n - 1 < m_fs) ? n - 1 : m_fs;
        rq.delete();
        pq.delete();
        for (int k = 1; k <= kmax; k++) begin
            f = (m_fn - k) & 255;
            for (int o = 0; o < m_cnt[f % n]; o += 2) begin
                e.k = k; e.f = f; e.off = o;
                e.pair = (o + 1 < m_cnt[f % n]);
                e.cyc = 0;
                rq.push_back(e);
            end
        end
        wb = 0;
        c = 0;
        while (1) begin
            @(negedge clk);
            start = inject && (c == 2);
            num_of_history_frames = 3'($urandom_range(0, 7));
            wr_valid = 1'($urandom_range(0, 1));
            wr_data_0 = $urandom;
            wr_data_1 = $urandom;
            #1;
            if (c > 0) check("cfg_err_quiet", cfg_err, 0);
            check("wr_ready", wr_ready, 32'(wb < beats));
            check("mem_we", mem_we, 32'(wr_valid && wb < beats));
            if (wr_valid && wb < beats) begin
                check("wr_frame", mem_frame_num, m_fn);
                check("wr_off0", mem_offset_0, 2 * wb);
                check("wr_off1", mem_offset_1, (2 * wb + 1) & 127);
                check("wr_csb0", mem_csb_0, 0);
                check("wr_csb1", mem_csb_1, 32'(2 * wb + 1 == cnt));
                check("wr_data0", mem_data_in_0, wr_data_0);
                if (2 * wb + 1 < cnt) check("wr_data1", mem_data_in_1, wr_data_1);
                ref_d[m_fn][2 * wb] = wr_data_0;
                if (2 * wb + 1 < cnt) ref_d[m_fn][2 * wb + 1] = wr_data_1;
                wb++;
            end
            if (!mem_oeb) begin
                check("rd_after_write", wb, beats);
                if (rq.size() == 0) begin
                    check("rd_extra_issue", 1, 0);
                end else begin
                    e = rq.pop_front();
                    check("rd_frame", mem_frame_num, e.f);
                    check("rd_off0", mem_offset_0, e.off);
                    check("rd_csb0", mem_csb_0, 0);
                    check("rd_csb1", mem_csb_1, 32'(!e.pair));
                    e.cyc = c;
                    pq.push_back(e);
                end
            end
            if (rd_valid) begin
                if (pq.size() == 0) begin
                    check("rd_valid_extra", 1, 0);
                end else begin
                    e = pq.pop_front();
                    check("rd_latency", c, e.cyc + 1);
                    check("rd_depth", rd_hist_depth, e.k);
                    check("rd_offset", rd_offset, e.off);
                    check("rd_pair", rd_pair, 32'(e.pair));
                    check("rd_data0", rd_data_0, ref_d[e.f][e.off]);
                    if (e.pair) check("rd_data1", rd_data_1, ref_d[e.f][e.off + 1]);
                end
            end
            if (done) begin
                check("beats_at_done", wb, beats);
                check("issues_left", rq.size(), 0);
                check("returns_left", pq.size(), 0);
                break;
            end
            c++;
            if (c > 4000) begin
                check("frame_timeout", 1, 0);
                break;
            end
        end
        @(negedge clk);
        start = 1'b0;
        wr_valid = 1'b0;
        #1;
        check("frame_num_next", frame_num, (m_fn + 1) & 255);
        check("busy_after", busy, 0);
        check("done_pulse", done, 0);
        m_cnt[m_fn % n] = cnt;
        m_n = n;
        m_fs = (m_fn == 255) ? 0 : ((m_fs + 1 < n - 1) ? m_fs + 1 : n - 1);
        m_fn = (m_fn + 1) & 255;
    endtask

    task automatic reset_mid_write();
        int n;
        n = (m_fn == 0) ? 2 : m_n;
        @(negedge clk);
        start = 1'b1;
        num_of_history_frames = 3'(n);
        obj_count = 7'd30;
        @(posedge clk);
        #1;
        check("abort_busy", busy, 1);
        @(negedge clk);
        start = 1'b0;
        wr_valid = 1'b1;
        @(negedge clk);
        wr_valid = 1'b1;
        #1;
        check("abort_pre_we", mem_we, 1);
        #2;
        reset = 1'b1;
        #1;
        check("abort_we", mem_we, 0);
        check("abort_csb0", mem_csb_0, 1);
        check("abort_csb1", mem_csb_1, 1);
        check("abort_oeb", mem_oeb, 1);
        check("abort_ready", wr_ready, 0);
        check("abort_busy_rst", busy, 0);
        check("abort_frame_num", frame_num, 0);
        @(negedge clk);
        reset = 1'b0;
        wr_valid = 1'b0;
        @(posedge clk);
        #1;
        check("abort_idle", busy, 0);
        check("abort_fn_idle", frame_num, 0);
        model_reset();
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        num_of_history_frames = '0;
        obj_count = '0;
        wr_valid = 1'b0;
        wr_data_0 = '0;
        wr_data_1 = '0;
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        check("rst_frame_num", frame_num, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_cfg_err", cfg_err, 0);
        check("rst_wr_ready", wr_ready, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_we", mem_we, 0);
        check("rst_csb0", mem_csb_0, 1);
        check("rst_csb1", mem_csb_1, 1);
        check("rst_oeb", mem_oeb, 1);
        check("rst_mem_frame", mem_frame_num, 0);
        @(negedge clk);
        reset = 1'b0;

        run_frame(3, 5, 0);

        do_reset();
        run_frame(3, 4, 0);
        run_frame(3, 2, 0);
        run_frame(3, 6, 0);
        run_frame(3, $urandom_range(0, 60), 1);
        run_frame(4, 10, 0);
        for (int i = 0; i < 6; i++)
            run_frame(3, $urandom_range(0, 60), 1'($urandom_range(0, 1)));

        do_reset();
        run_frame(0, 5, 0);
        run_frame(6, 5, 0);
        run_frame(5, 40, 0);
        run_frame(5, 25, 0);
        for (int i = 0; i < 5; i++)
            run_frame(5, $urandom_range(0, 40), 1);

        do_reset();
        run_frame(1, 127, 0);
        run_frame(1, $urandom_range(0, 127), 0);

        do_reset();
        while (m_fn != 255)
            run_frame(2, $urandom_range(0, 5), 1'($urandom_range(0, 3) == 0));
        run_frame(2, 7, 0);
        run_frame(2, 4, 0);
        run_frame(2, 3, 0);

        reset_mid_write();
        for (int i = 0; i < 8; i++)
            run_frame(4, $urandom_range(0, 40), 1'($urandom_range(0, 1)));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
